// File: rtl/bounce_generator.sv
// rtl/bounce_generator.sv - emulated mechanical switch: clean level in, bouncy level out
//
// Purpose: on each change of clean_in, drive a burst of 2K+1 toggles on
// bouncy_out whose spacing is 1..bounce_time cycles, ending at the new level.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           synchronous active-high reset (overrides ena)
//   ena           clock enable; when low every register holds
//   clean_in      ideal switch level to emulate
//   bounce_time   [N] maximum cycles between toggles within a burst
//   bounce_count  [M] extra toggle pairs per burst (K)
//   bouncy_out    registered emulated switch output
//   busy          registered, high while a burst is in progress

module bounce_generator #(
  parameter int          N         = 8,
  parameter int          M         = 4,
  parameter int          RANDOM    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         clean_in,
  input  logic [N-1:0] bounce_time,
  input  logic [M-1:0] bounce_count,
  output logic         bouncy_out,
  output logic         busy
);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t       state, state_nx;
  logic         target, target_nx;
  logic         out_nx, busy_nx;
  logic [N-1:0] cnt, cnt_nx;
  logic [N-1:0] bt_lat, bt_nx;
  logic [M:0]   toggles_left, toggles_left_nx;
  logic [15:0]  lfsr, lfsr_nx;
  logic [N-1:0] bt_sel, r, interval;

  // Galois LFSR, right shift, taps 16'hB400; advances every enabled cycle.
  assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // In IDLE the burst is being launched this cycle, so the live bounce_time
  // is the value being latched; in BOUNCE use the latched copy.
  assign bt_sel = (state == IDLE) ? bounce_time : bt_lat;
  assign r      = lfsr[N-1:0];

  // Interval clamped into [1, bt]; only consumed when bt is nonzero.
  always_comb begin
    interval = bt_sel;
    if (RANDOM != 0) begin
      if (r == '0)
        interval = N'(1);
      else if (r > bt_sel)
        interval = bt_sel;
      else
        interval = r;
    end
  end

  always_comb begin
    state_nx        = state;
    target_nx       = target;
    out_nx          = bouncy_out;
    busy_nx         = busy;
    cnt_nx          = cnt;
    bt_nx           = bt_lat;
    toggles_left_nx = toggles_left;
    case (state)
      IDLE: begin
        // Level compare, so a change made while disabled or busy is still seen.
        if (clean_in != target) begin
          target_nx = clean_in;
          bt_nx     = bounce_time;
          if (bounce_count == '0 || bounce_time == '0) begin
            out_nx = clean_in;
          end else begin
            out_nx          = ~bouncy_out;
            toggles_left_nx = {bounce_count, 1'b0};
            cnt_nx          = interval;
            state_nx        = BOUNCE;
            busy_nx         = 1'b1;
          end
        end
      end
      BOUNCE: begin
        // Counter value 1 marks the edge on which the next toggle lands.
        if (cnt == N'(1)) begin
          out_nx          = ~bouncy_out;
          toggles_left_nx = toggles_left - 1'b1;
          if (toggles_left == (M+1)'(1)) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end else begin
            cnt_nx = interval;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      target       <= 1'b0;
      bouncy_out   <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      bt_lat       <= '0;
      toggles_left <= '0;
      lfsr         <= LFSR_SEED;
    end else if (ena) begin
      state        <= state_nx;
      target       <= target_nx;
      bouncy_out   <= out_nx;
      busy         <= busy_nx;
      cnt          <= cnt_nx;
      bt_lat       <= bt_nx;
      toggles_left <= toggles_left_nx;
      lfsr         <= lfsr_nx;
    end
  end

endmodule
